fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end. It issues credit-limited
// sequential fetch requests and queues in-order responses with their PCs for
// the decoder. A redirect flushes the queue and marks in-flight fetches stale.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mem_req_valid/ready  fetch request handshake; mem_req_addr = byte address
//   mem_rsp_valid/data   in-order fetch response, no backpressure
//   instr_valid/ready    queue head handshake toward the decoder
//   instr_data/pc        head instruction word and its address
//   redirect_valid/pc    branch/jump redirect
//   fault                misaligned-redirect trap flag
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
// When it is undefined, fault is tied 0 and redirect targets are force-aligned.
module fetch_unit #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(DATA_W / 8 - 1);
    localparam logic [CNT_W:0]    DEPTH    = (CNT_W + 1)'(QUEUE_DEPTH);

    logic [DATA_W-1:0] data_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0] ipc_q  [QUEUE_DEPTH];

    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  infl_q, infl_d;
    logic [CNT_W-1:0]  stale_q, stale_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [ADDR_W-1:0] tgt_pc;
    logic              fault_q;
    logic              credit_ok, req_hs, push, pop, rsp_dec;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_d;
    logic misalign;

    assign misalign = |(redirect_pc & OFF_MASK);
    assign tgt_pc   = redirect_pc;

    // Only a redirect can change the trap state: misaligned sets, aligned clears.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = misalign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign tgt_pc  = redirect_pc & ~OFF_MASK;
    assign fault_q = 1'b0;
`endif

    assign fault = fault_q;

    // Credits cover both queued words and words still in flight, so every
    // response always has a free slot and the queue cannot overflow.
    assign credit_ok = ({1'b0, infl_q} + {1'b0, cnt_q}) < DEPTH;

    assign mem_req_valid = !rst && credit_ok && !redirect_valid && !fault_q;
    assign mem_req_addr  = pc_q;
    assign req_hs        = mem_req_valid && mem_req_ready;

    assign instr_valid = (cnt_q != '0);
    assign instr_data  = instr_valid ? data_q[rd_q] : '0;
    assign instr_pc    = instr_valid ? ipc_q[rd_q] : '0;
    assign pop         = instr_valid && instr_ready;

    // Responses to pre-redirect requests are dropped while stale_q drains.
    assign push    = mem_rsp_valid && (stale_q == '0);
    assign rsp_dec = mem_rsp_valid && (infl_q != '0);

    always_comb begin
        pc_d    = pc_q + (req_hs ? STRIDE : '0);
        rpc_d   = rpc_q + (push ? STRIDE : '0);
        infl_d  = infl_q + CNT_W'(req_hs) - CNT_W'(rsp_dec);
        stale_d = stale_q - CNT_W'(mem_rsp_valid && (stale_q != '0));
        cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_d    = wr_q + PTR_W'(push);
        rd_d    = rd_q + PTR_W'(pop);
        // Redirect wins over any push/pop; whatever is still outstanding
        // after this edge belongs to the old path.
        if (redirect_valid) begin
            pc_d    = tgt_pc;
            rpc_d   = tgt_pc;
            stale_d = infl_d;
            cnt_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            rpc_q   <= RESET_PC;
            infl_q  <= '0;
            stale_q <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            infl_q  <= infl_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Payload storage needs no reset; outputs are gated by instr_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= mem_rsp_data;
            ipc_q[wr_q]  <= rpc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit: directed scenarios and
// randomized traffic against a queue-based reference model and memory model.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    logic        mem_req_valid2;
    logic [31:0] mem_req_addr2;
    logic        instr_valid2;
    logic [31:0] instr_data2, instr_pc2;
    logic        fault2;

    fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid2),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr2),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid2),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data2),
        .instr_pc       (instr_pc2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    int out_n = 0;
    int stl = 0;
    int last_due = 0;
    bit flt_m = 0;
    logic [31:0] exp_req = '0;
    logic [31:0] q[$];
    mreq_t       mq[$];
    logic [31:0] req_log[$];
    logic [31:0] req_log2[$];
    logic [31:0] pop_log[$];

    logic        s_rst = 1'b1;
    logic        s_mrdy = 1'b0;
    logic        s_irdy = 1'b0;
    logic        s_rv = 1'b0;
    logic [31:0] s_rpc = '0;

    logic        o_rv, o_iv, o_flt, o_pop, rsp_now;
    logic [31:0] o_addr;

    logic [31:0] wrap_exp [4];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then
    // advance the reference model to match the coming rising edge.
    task automatic step();
        logic hs, exp_rv;
        int   due;
        @(negedge clk);
        rst            = s_rst;
        mem_req_ready  = s_mrdy;
        instr_ready    = s_irdy;
        redirect_valid = s_rv;
        redirect_pc    = s_rpc;
        rsp_now        = !s_rst && mq.size() > 0 && mq[0].due <= cyc;
        mem_rsp_valid  = rsp_now;
        mem_rsp_data   = rsp_now ? memf(mq[0].addr) : '0;
        #1;
        o_rv   = mem_req_valid;
        o_addr = mem_req_addr;
        o_iv   = instr_valid;
        o_flt  = fault;
        o_pop  = instr_valid && instr_ready;
        if (s_rst) begin
            check("rst_req_valid", 32'(mem_req_valid), 0);
            check("rst_instr_valid", 32'(instr_valid), 0);
            check("rst_instr_data", instr_data, 0);
            check("rst_instr_pc", instr_pc, 0);
            check("rst_fault", 32'(fault), 0);
            check("rst_wrap_outs",
                  32'({mem_req_valid2, instr_valid2, fault2}), 0);
            check("rst_wrap_head", instr_data2 | instr_pc2, 0);
            q.delete();
            mq.delete();
            out_n    = 0;
            stl      = 0;
            flt_m    = 0;
            exp_req  = '0;
            last_due = cyc;
        end else begin
            exp_rv = !s_rv && !flt_m && (out_n + q.size() < 4);
            check("req_valid", 32'(mem_req_valid), 32'(exp_rv));
            check("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
            check("fault", 32'(fault), 32'(flt_m));
            if (mem_req_valid)
                check("req_addr", mem_req_addr, exp_req);
            if (o_pop && q.size() > 0) begin
                check("instr_pc", instr_pc, q[0]);
                check("instr_data", instr_data, memf(q[0]));
            end
            hs = mem_req_valid && mem_req_ready;
            if (o_pop) begin
                pop_log.push_back(instr_pc);
                if (q.size() > 0) void'(q.pop_front());
            end
            if (rsp_now) begin
                assert (out_n > 0)
                    else $error("FAIL rsp_no_inflight at cycle %0d", cyc);
                out_n--;
                if (stl > 0) stl--;
                else q.push_back(mq[0].addr);
                void'(mq.pop_front());
            end
            if (hs) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{mem_req_addr, due});
                req_log.push_back(mem_req_addr);
                out_n++;
                exp_req = exp_req + 32'd4;
            end
            if (mem_req_valid2 && mem_req_ready)
                req_log2.push_back(mem_req_addr2);
            if (s_rv) begin
                q.delete();
                stl = out_n;
`ifdef FETCH_MISALIGN_TRAP_EN
                flt_m   = (s_rpc[1:0] != 2'b00);
                exp_req = s_rpc;
`else
                exp_req = s_rpc & ~32'h3;
`endif
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        step();
        step();
        s_rst = 1'b0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_log2.delete();
        pop_log.delete();
    endtask

    initial begin
        rst = 1'b1;
        mem_req_ready = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        // Fill with decoder stalled; also checks PC wrap on the second unit.
        lat = 1; s_mrdy = 1; s_irdy = 0; s_rv = 0;
        do_reset();
        clear_logs();
        repeat (8) step();
        check("t1_nreq", 32'(req_log.size()), 4);
        check("t1_wrap_nreq", 32'(req_log2.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_log.size())
                check("t1_addr", req_log[i], 32'(4 * i));
            if (i < req_log2.size())
                check("t1_wrap_addr", req_log2[i], wrap_exp[i]);
        end
        check("t1_full", 32'(o_iv), 1);

        // Single pop from a full queue frees exactly one credit.
        clear_logs();
        s_irdy = 1;
        step();
        s_irdy = 0;
        repeat (5) step();
        check("t2_npop", 32'(pop_log.size()), 1);
        if (pop_log.size() > 0) check("t2_pop_pc", pop_log[0], 32'h0);
        check("t2_nreq", 32'(req_log.size()), 1);
        if (req_log.size() > 0) check("t2_req", req_log[0], 32'h10);
        s_irdy = 1;
        repeat (12) step();
        for (int i = 1; i < 5; i++)
            if (i < pop_log.size())
                check("t2_order", pop_log[i], 32'(4 * i));

        // Redirect with two fetches outstanding on a 2-cycle memory.
        lat = 2; s_mrdy = 1; s_irdy = 1;
        do_reset();
        step();
        step();
        s_rv = 1; s_rpc = 32'h100;
        step();
        s_rv = 0;
        clear_logs();
        repeat (10) step();
        check("t3_npop", 32'(pop_log.size() > 0), 1);
        if (pop_log.size() > 0) check("t3_first_pc", pop_log[0], 32'h100);
        if (req_log.size() > 0) check("t3_first_req", req_log[0], 32'h100);

        // Redirect colliding with a pop and a response push.
        lat = 1; s_mrdy = 1; s_irdy = 1;
        do_reset();
        step();
        step();
        s_rv = 1; s_rpc = 32'h100;
        step();
        check("t4_pop", 32'(o_pop), 1);
        check("t4_push", 32'(rsp_now), 1);
        s_rv = 0; s_mrdy = 0;
        step();
        check("t4_iv_next", 32'(o_iv), 0);
        check("t4_rv_next", 32'(o_rv), 1);
        check("t4_addr_next", o_addr, 32'h100);
        step();
        check("t4_addr_hold", o_addr, 32'h100);
        s_mrdy = 1;
        repeat (10) step();

        // Misaligned redirect.
        s_rv = 1; s_rpc = 32'h102;
        step();
        s_rv = 0;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t5_fault", 32'(o_flt), 1);
        check("t5_rv_off", 32'(o_rv), 0);
        repeat (3) step();
        check("t5_rv_hold", 32'(o_rv), 0);
        s_rv = 1; s_rpc = 32'h200;
        step();
        s_rv = 0;
        step();
        check("t5_fault_clr", 32'(o_flt), 0);
        check("t5_rv_on", 32'(o_rv), 1);
        check("t5_addr", o_addr, 32'h200);
`else
        check("t5_fault", 32'(o_flt), 0);
        check("t5_rv_on", 32'(o_rv), 1);
        check("t5_addr", o_addr, 32'h100);
`endif
        repeat (8) step();

        // Randomized traffic; each segment starts with a mid-run reset.
        clear_logs();
        for (int seg = 0; seg < 3; seg++) begin
            lat = $urandom_range(1, 3);
            do_reset();
            for (int i = 0; i < 300; i++) begin
                s_mrdy = ($urandom_range(0, 3) != 0);
                s_irdy = ($urandom_range(0, 9) < 7);
                s_rv   = ($urandom_range(0, 19) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
                s_rpc  = $urandom & ~32'h3;
`else
                s_rpc  = $urandom;
`endif
                step();
            end
        end
        s_rv = 0;
        step();
        check("rand_flow", 32'(pop_log.size() > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
